// File: rtl/llc_mem_bridge_pkg.sv
// Shared sizes and FSM state type for the LLC-to-memory bridge.
// Optional write-acknowledge phase: LLC_MEM_BRIDGE_WR_ACK_EN.
`ifndef WORDS_PER_LINE
`define WORDS_PER_LINE 4
`endif
`ifndef BITS_PER_WORD
`define BITS_PER_WORD 32
`endif
`ifndef BITS_PER_LINE
`define BITS_PER_LINE (`WORDS_PER_LINE * `BITS_PER_WORD)
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef LINE_ADDR_BITS
`define LINE_ADDR_BITS 28
`endif
`ifndef HPROT_WIDTH
`define HPROT_WIDTH 2
`endif

package llc_mem_bridge_pkg;
    localparam int unsigned LLC_MEM_WORDS_PER_LINE = `WORDS_PER_LINE;
    localparam int unsigned LLC_MEM_WORD_BITS      = `BITS_PER_WORD;
    localparam int unsigned BITS_PER_LINE          = `BITS_PER_LINE;
    localparam int unsigned ADDR_BITS              = `ADDR_BITS;
    localparam int unsigned LINE_ADDR_BITS         = `LINE_ADDR_BITS;
    localparam int unsigned HPROT_WIDTH            = `HPROT_WIDTH;
    localparam int unsigned LLC_MEM_OFFSET_BITS    = ADDR_BITS - LINE_ADDR_BITS;
    localparam int unsigned LLC_MEM_BEAT_CNT_BITS  = $clog2(`WORDS_PER_LINE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_RSP
`ifdef LLC_MEM_BRIDGE_WR_ACK_EN
        , ST_WACK
`endif
    } llc_mem_bridge_state_t;
endpackage

// File: rtl/llc_mem_bridge_if.sv
// LLC request/response and word-wide memory channels of the bridge.
// Write-ack handshake present only with LLC_MEM_BRIDGE_WR_ACK_EN.
interface llc_mem_bridge_if
    import llc_mem_bridge_pkg::*;
#(
    parameter int unsigned WORD_BITS = LLC_MEM_WORD_BITS
);
    logic                      llc_mem_req_valid;
    logic                      llc_mem_req_ready;
    logic                      llc_mem_req_hwrite;
    logic [HPROT_WIDTH-1:0]    llc_mem_req_hprot;
    logic [LINE_ADDR_BITS-1:0] llc_mem_req_addr;
    logic [BITS_PER_LINE-1:0]  llc_mem_req_line;
    logic                      llc_mem_rsp_valid;
    logic                      llc_mem_rsp_ready;
    logic [BITS_PER_LINE-1:0]  llc_mem_rsp_line;
    logic                      mem_cmd_valid;
    logic                      mem_cmd_ready;
    logic                      mem_cmd_write;
    logic [HPROT_WIDTH-1:0]    mem_cmd_hprot;
    logic [ADDR_BITS-1:0]      mem_cmd_addr;
    logic                      mem_wdata_valid;
    logic                      mem_wdata_ready;
    logic [WORD_BITS-1:0]      mem_wdata;
    logic                      mem_wdata_last;
    logic                      mem_rdata_valid;
    logic                      mem_rdata_ready;
    logic [WORD_BITS-1:0]      mem_rdata;
    logic                      mem_rdata_last;
    logic                      mem_err;
`ifdef LLC_MEM_BRIDGE_WR_ACK_EN
    logic                      mem_wack_valid;
    logic                      mem_wack_ready;
`endif

    modport slave (
        input  llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_hprot,
               llc_mem_req_addr, llc_mem_req_line, llc_mem_rsp_ready,
               mem_cmd_ready, mem_wdata_ready, mem_rdata_valid, mem_rdata,
               mem_rdata_last,
`ifdef LLC_MEM_BRIDGE_WR_ACK_EN
        input  mem_wack_valid,
        output mem_wack_ready,
`endif
        output llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line,
               mem_cmd_valid, mem_cmd_write, mem_cmd_hprot, mem_cmd_addr,
               mem_wdata_valid, mem_wdata, mem_wdata_last, mem_rdata_ready,
               mem_err
    );

    modport master (
        output llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_hprot,
               llc_mem_req_addr, llc_mem_req_line, llc_mem_rsp_ready,
               mem_cmd_ready, mem_wdata_ready, mem_rdata_valid, mem_rdata,
               mem_rdata_last,
`ifdef LLC_MEM_BRIDGE_WR_ACK_EN
        output mem_wack_valid,
        input  mem_wack_ready,
`endif
        input  llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line,
               mem_cmd_valid, mem_cmd_write, mem_cmd_hprot, mem_cmd_addr,
               mem_wdata_valid, mem_wdata, mem_wdata_last, mem_rdata_ready,
               mem_err
    );
endinterface

// File: rtl/llc_mem_bridge_line_shifter.sv
// Line register of the bridge: whole-line load, per-word write and word select
// indexed by the beat counter.
module llc_mem_line_shifter
    import llc_mem_bridge_pkg::*;
#(
    parameter int unsigned WORDS     = LLC_MEM_WORDS_PER_LINE,
    parameter int unsigned WORD_BITS = LLC_MEM_WORD_BITS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_load,
    input  logic [BITS_PER_LINE-1:0]         i_line,
    input  logic                             i_wr,
    input  logic [LLC_MEM_BEAT_CNT_BITS-1:0] i_idx,
    input  logic [WORD_BITS-1:0]             i_word,
    output logic [BITS_PER_LINE-1:0]         o_line,
    output logic [WORD_BITS-1:0]             o_word
);
    logic [BITS_PER_LINE-1:0] r_line;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line <= i_line;
        end else if (i_wr) begin
            for (int unsigned w = 0; w < WORDS; w++) begin
                if (i_idx == LLC_MEM_BEAT_CNT_BITS'(w))
                    r_line[w*WORD_BITS +: WORD_BITS] <= i_word;
            end
        end
    end

    always_comb begin
        o_word = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (i_idx == LLC_MEM_BEAT_CNT_BITS'(w))
                o_word = r_line[w*WORD_BITS +: WORD_BITS];
        end
    end

    assign o_line = r_line;
endmodule

// File: rtl/llc_mem_bridge.sv
// Serializes whole-line LLC memory requests onto a word-wide memory port, one
// transaction at a time. Optional write-ack wait: LLC_MEM_BRIDGE_WR_ACK_EN.
module llc_mem_bridge
    import llc_mem_bridge_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = LLC_MEM_WORDS_PER_LINE,
    parameter int unsigned WORD_BITS      = LLC_MEM_WORD_BITS
) (
    input  logic            clk,
    input  logic            rst,
    llc_mem_bridge_if.slave bus
);
    localparam logic [LLC_MEM_BEAT_CNT_BITS-1:0] LAST_IDX =
        LLC_MEM_BEAT_CNT_BITS'(WORDS_PER_LINE - 1);

    llc_mem_bridge_state_t             r_state, w_next;
    logic                              r_live, r_hwrite, r_err;
    logic [HPROT_WIDTH-1:0]            r_hprot;
    logic [LINE_ADDR_BITS-1:0]         r_addr;
    logic [LLC_MEM_BEAT_CNT_BITS-1:0]  r_cnt;
    logic                              w_req_fire, w_cmd_fire, w_wbeat, w_rbeat, w_last;
    logic [WORD_BITS-1:0]              w_wword;
    logic [BITS_PER_LINE-1:0]          w_line;

    assign w_last     = (r_cnt == LAST_IDX);
    assign w_req_fire = r_live && (r_state == ST_IDLE) && bus.llc_mem_req_valid;
    assign w_cmd_fire = (r_state == ST_CMD) && bus.mem_cmd_ready;
    assign w_wbeat    = (r_state == ST_WDATA) && bus.mem_wdata_ready;
    assign w_rbeat    = (r_state == ST_RDATA) && bus.mem_rdata_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // r_live keeps request-ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live   <= 1'b0;
            r_hwrite <= 1'b0;
            r_hprot  <= '0;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_req_fire) begin
                r_hwrite <= bus.llc_mem_req_hwrite;
                r_hprot  <= bus.llc_mem_req_hprot;
                r_addr   <= bus.llc_mem_req_addr;
                r_cnt    <= '0;
            end else if (w_wbeat || w_rbeat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_rbeat && (bus.mem_rdata_last != w_last))
                r_err <= 1'b1;
        end
    end

    always_comb begin
        w_next                = r_state;
        bus.llc_mem_req_ready = 1'b0;
        bus.mem_cmd_valid     = 1'b0;
        bus.mem_wdata_valid   = 1'b0;
        bus.mem_rdata_ready   = 1'b0;
        bus.llc_mem_rsp_valid = 1'b0;
`ifdef LLC_MEM_BRIDGE_WR_ACK_EN
        bus.mem_wack_ready    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                bus.llc_mem_req_ready = r_live;
                if (w_req_fire) w_next = ST_CMD;
            end
            ST_CMD: begin
                bus.mem_cmd_valid = 1'b1;
                if (w_cmd_fire) w_next = r_hwrite ? ST_WDATA : ST_RDATA;
            end
            ST_WDATA: begin
                bus.mem_wdata_valid = 1'b1;
`ifdef LLC_MEM_BRIDGE_WR_ACK_EN
                if (w_wbeat && w_last) w_next = ST_WACK;
`else
                if (w_wbeat && w_last) w_next = ST_IDLE;
`endif
            end
            ST_RDATA: begin
                bus.mem_rdata_ready = 1'b1;
                if (w_rbeat && w_last) w_next = ST_RSP;
            end
            ST_RSP: begin
                bus.llc_mem_rsp_valid = 1'b1;
                if (bus.llc_mem_rsp_ready) w_next = ST_IDLE;
            end
`ifdef LLC_MEM_BRIDGE_WR_ACK_EN
            ST_WACK: begin
                bus.mem_wack_ready = 1'b1;
                if (bus.mem_wack_valid) w_next = ST_IDLE;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    llc_mem_line_shifter #(
        .WORDS     (WORDS_PER_LINE),
        .WORD_BITS (WORD_BITS)
    ) u_line (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_req_fire),
        .i_line (bus.llc_mem_req_line),
        .i_wr   (w_rbeat),
        .i_idx  (r_cnt),
        .i_word (bus.mem_rdata),
        .o_line (w_line),
        .o_word (w_wword)
    );

    assign bus.mem_cmd_write    = r_hwrite;
    assign bus.mem_cmd_hprot    = r_hprot;
    assign bus.mem_cmd_addr     = {r_addr, {LLC_MEM_OFFSET_BITS{1'b0}}};
    assign bus.mem_wdata        = w_wword;
    assign bus.mem_wdata_last   = w_last;
    assign bus.llc_mem_rsp_line = w_line;
    assign bus.mem_err          = r_err;
endmodule

// File: doc/llc_mem_bridge.md
# llc_mem_bridge

Downstream neighbour of the LLC core: accepts whole-line memory requests from the `llc_mem_req` channel and serializes them onto a word-wide memory port (command, write-data, read-data channels). For reads it collects `WORDS_PER_LINE` beats into one line and returns it on the `llc_mem_rsp` channel. It handles one transaction at a time. Its backpressure is the only flow control the LLC sees toward memory.

## Interface
- `WORDS_PER_LINE`, default `` `WORDS_PER_LINE ``, number of beats per line (power of two, ≥2).
- `WORD_BITS`, default `` `BITS_PER_WORD ``, beat width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `llc_mem_req_valid` in 1 / `llc_mem_req_ready` out 1: request handshake.
- `llc_mem_req_hwrite` in 1: 1 = write line, 0 = read line.
- `llc_mem_req_hprot` in `` `HPROT_WIDTH ``: protection bits, forwarded.
- `llc_mem_req_addr` in `` `LINE_ADDR_BITS ``: line address.
- `llc_mem_req_line` in `` `BITS_PER_LINE ``: write data.
- `llc_mem_rsp_valid` out 1 / `llc_mem_rsp_ready` in 1: response handshake.
- `llc_mem_rsp_line` out `` `BITS_PER_LINE ``: read line.
- `mem_cmd_valid` out 1 / `mem_cmd_ready` in 1: command handshake.
- `mem_cmd_write` out 1, `mem_cmd_hprot` out `` `HPROT_WIDTH ``, `mem_cmd_addr` out `` `ADDR_BITS ``: byte address = {line addr, zero offset}.
- `mem_wdata_valid` out 1 / `mem_wdata_ready` in 1, `mem_wdata` out `WORD_BITS`, `mem_wdata_last` out 1.
- `mem_rdata_valid` in 1 / `mem_rdata_ready` out 1, `mem_rdata` in `WORD_BITS`, `mem_rdata_last` in 1.
- `mem_err` out 1: sticky protocol error.

## Operation
- FSM states: IDLE, CMD, WDATA, RDATA, RSP, and WACK (only with the macro).
- IDLE: `llc_mem_req_ready`=1. On handshake, the block registers hwrite, hprot, addr and line, clears the beat counter, and goes to CMD.
- CMD: `mem_cmd_valid`=1. On `mem_cmd_ready`, go to WDATA if write, else RDATA.
- WDATA: `mem_wdata`=line word[cnt], i.e. bits [cnt*WORD_BITS +: WORD_BITS], word 0 first. `mem_wdata_last`=(cnt==WORDS_PER_LINE-1). Each accepted beat increments cnt. After the last beat: go to WACK if the macro is defined, else IDLE.
- RDATA: `mem_rdata_ready`=1. Each accepted beat writes word[cnt] of the line register and increments cnt. After beat WORDS_PER_LINE-1, go to RSP.
- RSP: `llc_mem_rsp_valid`=1 and `llc_mem_rsp_line` is held stable. On `llc_mem_rsp_ready`, go to IDLE.
- The beat counter is authoritative. If `mem_rdata_last` disagrees with (cnt==WORDS_PER_LINE-1) on an accepted beat, `mem_err` sets and stays set until reset; the transfer still completes on the counter.
- Counter width is log2(WORDS_PER_LINE). It wraps to 0 on the final beat.

## Timing
- Reset values: all valids 0, `llc_mem_req_ready` 0 during reset and 1 in the first cycle after reset, line and address registers 0, `mem_err` 0, state IDLE.
- All outputs are driven from registers or from state decode. No combinational path runs from any input to any valid/ready output.
- Read latency with zero memory stall: req accept at cycle 0, cmd at cycle 1, beats at cycles 2..W+1, rsp valid at cycle W+2.
- Write with zero stall: cmd at cycle 1, beats at cycles 2..W+1, ready again at cycle W+2.
- A valid stays asserted, with payload stable, until its ready is seen. Stalls of any length are legal on every channel.
- `mem_rdata_valid` outside RDATA is not accepted (ready=0) and does not set `mem_err`.
- Asynchronous reset mid-transaction aborts it immediately. Any partial line is discarded and no response is issued.

## Configuration
- `LLC_MEM_BRIDGE_WR_ACK_EN` defined:
  - Adds ports `mem_wack_valid` in 1 and `mem_wack_ready` out 1, plus the WACK state.
  - After the last write beat the FSM waits in WACK with `mem_wack_ready`=1. It returns to IDLE on `mem_wack_valid`, so each write is ordered before the next request.
- Undefined: the ports and the WACK state are absent, and writes are posted, returning to IDLE straight after the last beat.

## Structure
- Shared package:
  - A state enum typedef `llc_mem_bridge_state_t`.
  - `LLC_MEM_BEAT_CNT_BITS` = $clog2(`WORDS_PER_LINE`).
  - The existing `` `LINE_ADDR_BITS ``, `` `BITS_PER_LINE ``, `` `ADDR_BITS `` and `` `HPROT_WIDTH `` constants from the cache constants header.
- One natural sub-module, `llc_mem_line_shifter`: the line register with per-word load and select, indexed by the beat counter. The FSM and handshakes stay in the top module.

## Test plan
- Read, W=4, no stalls: addr 0x1234, memory returns words A0..A3 with last on beat 3. Response line = {A3,A2,A1,A0}; `mem_cmd_addr` = 0x1234 shifted left by the offset bits; rsp valid at cycle 6.
- Write, W=4: line {D3,D2,D1,D0}, `mem_wdata_ready` toggling 1010… Beats D0..D3 appear in order, last only with D3, and no beat is duplicated or skipped.
- Backpressure: `mem_cmd_ready` low for 5 cycles, then `llc_mem_rsp_ready` low for 3 cycles. Valids and payloads stay stable; `llc_mem_req_ready` stays 0 until the response is taken.
- Protocol error: `mem_rdata_last` asserted on beat 1. `mem_err` goes to 1, 4 beats are still collected, the response is delivered, and `mem_err` stays 1.
- Reset mid-read after 2 beats. All valids drop to 0 asynchronously; after release, a fresh read completes correctly with no stale words.
- `LLC_MEM_BRIDGE_WR_ACK_EN`: write, then a read presented immediately. The read is not accepted until `mem_wack_valid` is pulsed 10 cycles later.
